pwm_output_stage: RTL
=====================

Name: pwm_output_stage

Overview:
- Downstream consumer of the PID controller's 8-bit control word.
- Converts the control word into a fixed-frequency PWM drive with a complementary output and programmable dead-time.
- Duty updates are double-buffered and applied only at period boundaries, so the PWM never sees a glitched period.
- Sits between pid_controller.control_signal and the chip output pins.

Parameters:
- CNT_WIDTH, 8, period counter width; PWM period = 2^CNT_WIDTH clocks; must be >= 8.
- DEADTIME, 2, blanking clocks at the start of every high/low run of the raw PWM; 0 disables blanking; legal range 0..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- duty_in  input  8  requested duty (control word from PID stage).
- duty_valid  input  1  one-cycle strobe; captures duty_in into the shadow register.
- enable  input  1  run control; low holds the counter and forces both outputs low.
- pwm_out  output  1  high-side drive, registered.
- pwm_out_n  output  1  low-side (complementary) drive, registered.
- period_start  output  1  one-cycle pulse marking the first output cycle of each period, registered.
- duty_active  output  8  duty value currently in use, registered.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled only on a clk rising edge.
- Reset state: cnt=0, shadow=0, pending=0, duty_active=0, run-length counter=0, pwm_out=0, pwm_out_n=0, period_start=0.
- Counter: cnt is CNT_WIDTH bits, MAX = 2^CNT_WIDTH-1.
  - enable=1: cnt <= (cnt==MAX) ? 0 : cnt+1.
  - enable=0: cnt <= 0.
- Shadow register: duty_valid=1 sets shadow <= duty_in and pending <= 1. A later strobe before the load overwrites the shadow; last value wins.
- Load rule, enable=1: on a cycle with cnt==MAX:
  - if duty_valid=1, duty_active <= duty_in (bypasses the shadow);
  - else if pending=1, duty_active <= shadow;
  - pending clears in either case.
  - No other cycle changes duty_active while enabled.
- Load rule, enable=0: the same load (bypass, else shadow) happens on every cycle, so the newest value is live when enable rises.
- Compare value: cmp = duty_active << (CNT_WIDTH-8). Combinational raw = enable && (cnt < cmp).
  - duty 0: raw always 0.
  - duty 0xFF at CNT_WIDTH=8: raw high 255 of 256 cycles.
- Dead-time, tracked by a run-length counter rl:
  - rl counts consecutive cycles raw has held its current value, saturating at DEADTIME+1.
  - rl resets to 1 when raw changes, and to 0 when enable=0.
  - pwm_out <= raw && (rl_next > DEADTIME).
  - pwm_out_n <= enable && !raw && (rl_next > DEADTIME).
  - Effect: the first DEADTIME cycles of every high run and every low run are blanked. A run of length <= DEADTIME produces no pulse on that output (pulse swallowed).
  - pwm_out and pwm_out_n are never high simultaneously. With DEADTIME=0 they are exact complements while enabled.
- Latency: all outputs are registered one clock after the cnt value they reflect.
- period_start <= enable && (cnt==0). It aligns with the first output cycle of each period.
- Runs crossing the period boundary (e.g. duty 0 held across periods) are continuous; no re-blanking at the boundary.
- Disable mid-period: on the next edge cnt=0, pwm_out=0, pwm_out_n=0, period_start=0. duty_active, shadow and pending follow the disabled load rule.
- Re-enable: the first enabled cycle has cnt=0. period_start pulses one clock later. Both outputs start with DEADTIME blanking.
- Reset mid-period: rst_n=0 overrides all of the above; the reset state takes effect on that edge.

Test Plan:
- Reset: rst_n=0 for 2 clocks with duty_valid=1, duty_in=0x80, enable=1 -> all outputs 0, duty_active=0x00, no period_start.
- DEADTIME=0, CNT_WIDTH=8, load 0x80 while disabled, then enable -> each period pwm_out high 128, pwm_out_n high 128, exact complements; period_start every 256 clocks.
- DEADTIME=2, duty 0x80 -> per period pwm_out high 126, pwm_out_n high 126; two 2-cycle gaps with both low; both never high together.
- Mid-period update: running at 0x40, strobe duty 0x20 at cnt=10, then 0xC0 at cnt=50 -> duty_active stays 0x40 until the edge after cnt==MAX, then becomes 0xC0; next period pwm_out high 192-2=190.
- Boundaries, DEADTIME=2: duty 0x01 -> pwm_out never high, pwm_out_n high 253 per period. Duty 0x00 -> pwm_out never high, pwm_out_n continuously high after 2 blanking cycles. Strobe exactly at cnt==MAX -> value applies to the immediately following period.
- Enable drop at cnt=100 then re-enable after 5 clocks -> both outputs 0 on the next edge. On re-enable, cnt restarts at 0, period_start pulses one clock later, first high run is blanked 2 cycles.

Source files
------------

// File: rtl/pwm_output_stage.sv
// Fixed-frequency PWM stage with complementary output, dead-time blanking and
// period-aligned double-buffered duty updates.
module pwm_output_stage #(
    parameter int CNT_WIDTH = 8,
    parameter int DEADTIME  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    input  logic       enable,
    output logic       pwm_out,
    output logic       pwm_out_n,
    output logic       period_start,
    output logic [7:0] duty_active
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam int                   RL_W    = 5;
    localparam logic [RL_W-1:0]      RL_SAT  = RL_W'(DEADTIME + 1);
    localparam logic [RL_W-1:0]      DT      = RL_W'(DEADTIME);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cmp;
    logic [7:0]           shadow;
    logic                 pending;
    logic [RL_W-1:0]      rl;
    logic [RL_W-1:0]      rl_next;
    logic                 raw;
    logic                 raw_prev;
    logic                 load;

    // While disabled every cycle is a load cycle, so the newest duty is live at enable.
    always_comb begin
        cmp     = CNT_WIDTH'(duty_active) << (CNT_WIDTH - 8);
        raw     = enable && (cnt < cmp);
        load    = !enable || (cnt == CNT_MAX);
        rl_next = '0;
        if (enable) begin
            if (raw != raw_prev)
                rl_next = RL_W'(1);
            else if (rl < RL_SAT)
                rl_next = rl + 1'b1;
            else
                rl_next = rl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            duty_active  <= '0;
            rl           <= '0;
            raw_prev     <= 1'b0;
            pwm_out      <= 1'b0;
            pwm_out_n    <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt <= (enable && (cnt != CNT_MAX)) ? cnt + 1'b1 : '0;

            if (duty_valid)
                shadow <= duty_in;

            // A strobe on the load cycle bypasses the shadow so it is not lost.
            if (load) begin
                if (duty_valid)
                    duty_active <= duty_in;
                else if (pending)
                    duty_active <= shadow;
                pending <= 1'b0;
            end else if (duty_valid) begin
                pending <= 1'b1;
            end

            rl           <= rl_next;
            raw_prev     <= raw;
            pwm_out      <= raw && (rl_next > DT);
            pwm_out_n    <= enable && !raw && (rl_next > DT);
            period_start <= enable && (cnt == '0);
        end
    end
endmodule
